// File: rtl/dmem_ctrl_pkg.sv
// dmem_ctrl_pkg: funct3 and access-size codes, sequencer states, request legality check.
package dmem_ctrl_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [1:0] AS_BYTE = 2'b00;
  localparam logic [1:0] AS_HALF = 2'b01;
  localparam logic [1:0] AS_WORD = 2'b10;
  typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, RESP} state_t;
  function automatic logic req_bad(input logic we, input logic [2:0] f3, input logic [1:0] a);
    return (we ? !(f3 == F3_B || f3 == F3_H || f3 == F3_W)
               : !(f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU)) ||
           (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a != 2'b00);
  endfunction
endpackage

// File: rtl/dmem_lane_fmt.sv
// dmem_lane_fmt: load sign/zero extension and sb/sh merge into the old memory word.
module dmem_lane_fmt
  import dmem_ctrl_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] raw,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);
  always_comb begin
    load_data = funct3 == F3_B  ? {{24{raw[7]}}, raw[7:0]} :
                funct3 == F3_BU ? {24'b0, raw[7:0]} :
                funct3 == F3_H  ? {{16{raw[15]}}, raw[15:0]} :
                funct3 == F3_HU ? {16'b0, raw[15:0]} : raw;
    merged = funct3 == F3_B ? {old_word[31:8], wdata[7:0]} : {old_word[31:16], wdata[15:0]};
  end
endmodule

// File: rtl/dmem_lsu_ctrl.sv
// dmem_lsu_ctrl: one-at-a-time RV32 load/store sequencer; sb/sh become word read-modify-write.
// Define DMEM_BOUNDS_CHECK_EN to flag any access with addr+3 >= MEM_DEPTH as an error.
module dmem_lsu_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int MEM_DEPTH = 65536
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic [1:0]  mem_access_size,
  output logic        mem_read_write,
  input  logic [31:0] mem_data_out
);
`ifdef DMEM_BOUNDS_CHECK_EN
  localparam logic BOUNDS = 1'b1;
`else
  localparam logic BOUNDS = 1'b0;
`endif
  state_t state;
  logic [2:0] f3_q;
  logic [31:0] load_data, merged;
  logic oob, err_now;
  assign oob = {1'b0, req_addr} + 33'd3 >= 33'(MEM_DEPTH);
  assign err_now = req_bad(req_we, req_funct3, req_addr[1:0]) || (BOUNDS && oob);
  // Write enable comes from state alone so a reset can never leave a stray write behind.
  assign req_ready = state == IDLE;
  assign resp_valid = state == RESP;
  assign mem_read_write = state == WR;
  assign mem_access_size = AS_WORD;
  dmem_lane_fmt u_fmt (
    .funct3   (f3_q),
    .raw      (mem_data_out),
    .old_word (mem_data_out),
    .wdata    (mem_data_in),
    .load_data(load_data),
    .merged   (merged)
  );
  // Memory is always accessed as a full word at addr; the lane formatter works on its low bytes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      f3_q        <= F3_B;
      mem_address <= '0;
      mem_data_in <= '0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          f3_q        <= req_funct3;
          mem_address <= req_addr;
          mem_data_in <= req_wdata;
          if (err_now) begin
            resp_err   <= 1'b1;
            resp_rdata <= '0;
            state      <= RESP;
          end else begin
            state <= !req_we ? RD : req_funct3 == F3_W ? WR : RMW_RD;
          end
        end
        RD: begin
          resp_rdata <= load_data;
          resp_err   <= 1'b0;
          state      <= RESP;
        end
        RMW_RD: begin
          mem_data_in <= merged;
          state       <= WR;
        end
        WR: begin
          resp_rdata <= '0;
          resp_err   <= 1'b0;
          state      <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// tb_dmem_lsu_ctrl: directed and randomized checks of dmem_lsu_ctrl against a byte-array RV32 model.
module tb_dmem_lsu_ctrl;
  localparam int DEPTH = 512;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic req_valid = 1'b0, req_we = 1'b0;
  logic [2:0] req_funct3 = 3'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic req_ready, resp_valid, resp_err, mem_read_write;
  logic [31:0] resp_rdata, mem_address, mem_data_in, mem_data_out;
  logic [1:0] mem_access_size;
  logic [7:0] mem [DEPTH];
  logic [7:0] ref_mem [DEPTH];
  int n_cmp = 0, n_bad = 0;

  always #5 clock = ~clock;

  dmem_lsu_ctrl #(.MEM_DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_access_size(mem_access_size),
    .mem_read_write(mem_read_write), .mem_data_out(mem_data_out)
  );

  function automatic logic [7:0] rdb(input logic [31:0] a);
    return a < DEPTH ? mem[a] : 8'h00;
  endfunction
  assign mem_data_out = {rdb(mem_address + 32'd3), rdb(mem_address + 32'd2),
                         rdb(mem_address + 32'd1), rdb(mem_address)};
  always @(posedge clock)
    if (mem_read_write === 1'b1)
      for (int i = 0; i < 4; i++)
        if (mem_address + 32'(i) < DEPTH) mem[mem_address + 32'(i)] <= mem_data_in[8*i +: 8];

  // Reference model: RV32 semantics over a plain byte array.
  function automatic int acc_size(input logic [2:0] f3);
    return f3[1:0] == 2'b00 ? 1 : f3[1:0] == 2'b01 ? 2 : 4;
  endfunction
  function automatic logic exp_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
    logic legal;
    legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
`ifdef DMEM_BOUNDS_CHECK_EN
    if (64'(a) + 64'd3 >= 64'(DEPTH)) return 1'b1;
`endif
    return !legal || (a % acc_size(f3)) != 0;
  endfunction
  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a);
    int v;
    if (f3[1:0] == 2'b10) return {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
    v = (f3[1:0] == 2'b00) ? int'(ref_mem[a]) : int'(ref_mem[a]) + 256 * int'(ref_mem[a+1]);
    if (!f3[2] && f3[1:0] == 2'b00 && v >= 128) v -= 256;
    if (!f3[2] && f3[1:0] == 2'b01 && v >= 32768) v -= 65536;
    return 32'(v);
  endfunction
  task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    for (int i = 0; i < acc_size(f3); i++) ref_mem[a + 32'(i)] = wd[8*i +: 8];
  endtask

  // Issues one request and reports response, latency (negedges from accept) and write cycles seen.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic err, output int lat, output int nwr,
                        output logic [31:0] wdat);
    @(negedge clock);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    n_cmp++;
    if (req_ready !== 1'b1) begin n_bad++; $display("FAIL ready_idle: got %b want 1", req_ready); end
    @(negedge clock);
    req_valid = 1'b0;
    lat = 1; nwr = 0; wdat = '0;
    while (resp_valid !== 1'b1 && lat < 8) begin
      if (mem_read_write === 1'b1) begin nwr++; wdat = mem_data_in; end
      @(negedge clock);
      lat++;
    end
    if (lat >= 8) begin n_cmp++; n_bad++; $display("FAIL resp_timeout: no resp_valid within %0d cycles", lat); end
    rd = resp_rdata; err = resp_err;
  endtask

  task automatic test_reset();
    repeat (2) begin
      @(negedge clock);
      n_cmp++;
      if ({req_ready, resp_valid, resp_rdata, resp_err, mem_read_write, mem_address, mem_data_in, mem_access_size}
          !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b10}) begin
        n_bad++;
        $display("FAIL reset_outputs: got rdy=%b rv=%b rd=%h err=%b rw=%b addr=%h din=%h as=%b want 1 0 0 0 0 0 0 10",
                 req_ready, resp_valid, resp_rdata, resp_err, mem_read_write, mem_address, mem_data_in, mem_access_size);
      end
    end
    reset_n = 1'b1;
  endtask

  task automatic test_loads();
    logic [2:0] f3s [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
    logic [31:0] exps [5] = '{32'hFFFFFFBB, 32'h000000BB, 32'hFFFFAABB, 32'h0000AABB, 32'h8899AABB};
    logic [31:0] rd, wdat; logic err; int lat, nwr;
    for (int i = 0; i < 5; i++) begin
      do_req(1'b0, f3s[i], 32'h100, 32'h0, rd, err, lat, nwr, wdat);
      n_cmp++;
      if ({rd, err} !== {exps[i], 1'b0} || lat != 2 || nwr != 0) begin
        n_bad++;
        $display("FAIL load_f3_%0d: got rd=%h err=%b lat=%0d wr=%0d want rd=%h err=0 lat=2 wr=0",
                 f3s[i], rd, err, lat, nwr, exps[i]);
      end
    end
  endtask

  task automatic test_sub_word_store();
    logic [31:0] rd, wdat; logic err; int lat, nwr;
    do_req(1'b1, 3'd0, 32'h100, 32'h12345677, rd, err, lat, nwr, wdat);
    ref_store(3'd0, 32'h100, 32'h12345677);
    n_cmp++;
    if ({rd, err} !== 33'h0 || lat != 3 || nwr != 1 || wdat !== 32'h8899AA77) begin
      n_bad++;
      $display("FAIL sb_rmw: got rd=%h err=%b lat=%0d wr=%0d data=%h want 0 0 3 1 8899aa77", rd, err, lat, nwr, wdat);
    end
    do_req(1'b0, 3'd2, 32'h100, 32'h0, rd, err, lat, nwr, wdat);
    n_cmp++;
    if (rd !== 32'h8899AA77 || err !== 1'b0) begin
      n_bad++; $display("FAIL sb_readback: got %h err=%b want 8899aa77 err=0", rd, err);
    end
    do_req(1'b1, 3'd2, 32'h100, 32'h11223344, rd, err, lat, nwr, wdat);
    ref_store(3'd2, 32'h100, 32'h11223344);
    n_cmp++;
    if (err !== 1'b0 || lat != 2 || nwr != 1 || wdat !== 32'h11223344) begin
      n_bad++; $display("FAIL sw: got err=%b lat=%0d wr=%0d data=%h want 0 2 1 11223344", err, lat, nwr, wdat);
    end
    do_req(1'b1, 3'd1, 32'h102, 32'h0000CAFE, rd, err, lat, nwr, wdat);
    ref_store(3'd1, 32'h102, 32'h0000CAFE);
    n_cmp++;
    if (err !== 1'b0 || lat != 3 || nwr != 1) begin
      n_bad++; $display("FAIL sh_rmw: got err=%b lat=%0d wr=%0d want 0 3 1", err, lat, nwr);
    end
    do_req(1'b0, 3'd2, 32'h100, 32'h0, rd, err, lat, nwr, wdat);
    n_cmp++;
    if (rd !== 32'hCAFE3344) begin n_bad++; $display("FAIL sh_readback: got %h want cafe3344", rd); end
  endtask

  task automatic test_errors();
    logic we_t [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [2:0] f3_t [5] = '{3'd2, 3'd1, 3'd3, 3'd4, 3'd5};
    logic [31:0] a_t [5] = '{32'h102, 32'h101, 32'h100, 32'h100, 32'h103};
    logic [31:0] rd, wdat; logic err; int lat, nwr;
    for (int i = 0; i < 5; i++) begin
      do_req(we_t[i], f3_t[i], a_t[i], 32'hFFFFFFFF, rd, err, lat, nwr, wdat);
      n_cmp++;
      if ({rd, err} !== {32'h0, 1'b1} || lat != 1 || nwr != 0) begin
        n_bad++;
        $display("FAIL err_case_%0d: got rd=%h err=%b lat=%0d wr=%0d want rd=0 err=1 lat=1 wr=0", i, rd, err, lat, nwr);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] rd, wdat; logic err; int lat, nwr, bad_cyc;
    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h100; req_wdata = 32'h55;
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (mem_read_write !== 1'b1) begin n_bad++; $display("FAIL rst_reach_wr: got rw=%b want 1", mem_read_write); end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({req_ready, resp_valid, resp_rdata, resp_err, mem_read_write, mem_address, mem_data_in, mem_access_size}
        !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b10}) begin
      n_bad++;
      $display("FAIL rst_mid_outputs: got rdy=%b rv=%b rd=%h err=%b rw=%b addr=%h din=%h want reset values",
               req_ready, resp_valid, resp_rdata, resp_err, mem_read_write, mem_address, mem_data_in);
    end
    bad_cyc = 0;
    repeat (3) begin
      @(negedge clock);
      if (resp_valid !== 1'b0 || mem_read_write !== 1'b0) bad_cyc++;
    end
    reset_n = 1'b1;
    n_cmp++;
    if (bad_cyc != 0) begin n_bad++; $display("FAIL rst_quiet: got %0d active cycles want 0", bad_cyc); end
    do_req(1'b0, 3'd2, 32'h100, 32'h0, rd, err, lat, nwr, wdat);
    n_cmp++;
    if ({rd, err} !== {32'hCAFE3344, 1'b0} || lat != 2) begin
      n_bad++; $display("FAIL rst_recover_lw: got rd=%h err=%b lat=%0d want cafe3344 0 2", rd, err, lat);
    end
  endtask

  task automatic test_bounds();
    logic [31:0] rd, wdat; logic err; int lat, nwr;
    do_req(1'b0, 3'd2, 32'(DEPTH - 4), 32'h0, rd, err, lat, nwr, wdat);
    n_cmp++;
    if ({rd, err} !== {exp_load(3'd2, 32'(DEPTH - 4)), 1'b0} || lat != 2) begin
      n_bad++; $display("FAIL bound_last_word: got rd=%h err=%b lat=%0d want err=0 lat=2", rd, err, lat);
    end
    do_req(1'b0, 3'd2, 32'(DEPTH), 32'h0, rd, err, lat, nwr, wdat);
    n_cmp++;
`ifdef DMEM_BOUNDS_CHECK_EN
    if (err !== 1'b1 || rd !== 32'h0 || lat != 1 || nwr != 0) begin
      n_bad++; $display("FAIL bound_over: got rd=%h err=%b lat=%0d wr=%0d want 0 1 1 0", rd, err, lat, nwr);
    end
    do_req(1'b1, 3'd0, 32'(DEPTH - 3), 32'h0, rd, err, lat, nwr, wdat);
    n_cmp++;
    if (err !== 1'b1 || lat != 1 || nwr != 0) begin
      n_bad++; $display("FAIL bound_sb_edge: got err=%b lat=%0d wr=%0d want 1 1 0", err, lat, nwr);
    end
`else
    if (err !== 1'b0 || lat != 2) begin
      n_bad++; $display("FAIL nobound_pass: got err=%b lat=%0d want 0 2", err, lat);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic we_t [3] = '{1'b0, 1'b0, 1'b1};
    logic [2:0] f3_t [3] = '{3'd2, 3'd2, 3'd0};
    logic [31:0] a_t [3] = '{32'h100, 32'h102, 32'h180};
    int per_t [3] = '{3, 2, 4};
    int last, pulses;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      req_valid = 1'b1; req_we = we_t[k]; req_funct3 = f3_t[k]; req_addr = a_t[k]; req_wdata = 32'h000000A5;
      last = -1; pulses = 0;
      for (int c = 0; c < 14; c++) begin
        @(negedge clock);
        if (resp_valid === 1'b1) begin
          if (last >= 0) begin
            n_cmp++;
            if (c - last != per_t[k]) begin
              n_bad++; $display("FAIL b2b_gap_%0d: got %0d cycles want %0d", k, c - last, per_t[k]);
            end
          end
          last = c; pulses++;
        end
      end
      req_valid = 1'b0;
      repeat (5) @(negedge clock);
      n_cmp++;
      if (pulses < 14 / per_t[k] - 1) begin
        n_bad++; $display("FAIL b2b_count_%0d: got %0d responses want >= %0d", k, pulses, 14 / per_t[k] - 1);
      end
    end
    ref_store(3'd0, 32'h180, 32'h000000A5);
  endtask

  task automatic test_random();
    logic [31:0] rd, wdat, a, wd, e_rd; logic err, we, e_err; logic [2:0] f3; int lat, nwr, e_lat;
    logic [2:0] legal [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    for (int i = 0; i < 120; i++) begin
      we = 1'($urandom_range(0, 1));
      f3 = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7))
                                        : legal[we ? $urandom_range(0, 2) : $urandom_range(0, 4)];
      a = 32'($urandom_range(0, DEPTH - 4));
      if ($urandom_range(0, 3) != 0) a = a - (a % 32'(acc_size(f3)));
      wd = $urandom;
      e_err = exp_err(we, f3, a);
      e_rd = (we || e_err) ? 32'h0 : exp_load(f3, a);
      e_lat = e_err ? 1 : (we && acc_size(f3) < 4) ? 3 : 2;
      do_req(we, f3, a, wd, rd, err, lat, nwr, wdat);
      if (we && !e_err) ref_store(f3, a, wd);
      n_cmp++;
      if ({rd, err} !== {e_rd, e_err} || lat != e_lat || nwr != ((we && !e_err) ? 1 : 0)) begin
        n_bad++;
        $display("FAIL rand_%0d we=%b f3=%0d a=%h: got rd=%h err=%b lat=%0d wr=%0d want rd=%h err=%b lat=%0d wr=%0d",
                 i, we, f3, a, rd, err, lat, nwr, e_rd, e_err, e_lat, (we && !e_err) ? 1 : 0);
      end
    end
  endtask

  task automatic test_memory_image();
    int diffs = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) diffs++;
    n_cmp++;
    if (diffs != 0) begin n_bad++; $display("FAIL mem_image: got %0d differing bytes want 0", diffs); end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin mem[i] = 8'($urandom); ref_mem[i] = mem[i]; end
    {mem[32'h103], mem[32'h102], mem[32'h101], mem[32'h100]} = 32'h8899AABB;
    {ref_mem[32'h103], ref_mem[32'h102], ref_mem[32'h101], ref_mem[32'h100]} = 32'h8899AABB;
    test_reset();
    test_loads();
    test_sub_word_store();
    test_errors();
    test_reset_mid_write();
    test_bounds();
    test_back_to_back();
    test_random();
    test_memory_image();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
